// File: rtl/btn_press_classifier.sv
// btn_press_classifier: turns the debounced button level into one-cycle press/release/short/long/repeat events.
// Optional auto-repeat while held past the long threshold is built only when BTN_AUTOREPEAT_EN is defined.
module btn_press_classifier #(
    parameter int LONG_CYC   = 1000,
    parameter int REPEAT_CYC = 200,
    parameter int CNT_W      = 10
) (
    input  logic clk_slow,
    input  logic rst_n,
    input  logic btn_stable,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_press,
    output logic long_press,
    output logic repeat_pulse,
    output logic held
);
    typedef enum logic [1:0] {IDLE, PRESSED, LONG_HELD} state_t;
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
    if (LONG_CYC < 2 || REPEAT_CYC < 1 || (2 ** CNT_W) < LONG_CYC || (2 ** CNT_W) < REPEAT_CYC) begin : g_bad_params
        $error("btn_press_classifier: illegal LONG_CYC/REPEAT_CYC/CNT_W combination");
    end
    state_t state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic press_nxt, release_nxt, short_nxt, long_nxt, repeat_nxt;
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        short_nxt   = 1'b0;
        long_nxt    = 1'b0;
        repeat_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (btn_stable) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                    press_nxt = 1'b1;
                end
            end
            PRESSED: begin
                // release wins over the long threshold on the same edge
                if (!btn_stable) begin
                    state_nxt   = IDLE;
                    cnt_nxt     = '0;
                    short_nxt   = 1'b1;
                    release_nxt = 1'b1;
                end else if (cnt == LONG_LAST) begin
                    state_nxt = LONG_HELD;
                    cnt_nxt   = '0;
                    long_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            LONG_HELD: begin
                if (!btn_stable) begin
                    state_nxt   = IDLE;
                    cnt_nxt     = '0;
                    release_nxt = 1'b1;
                end else begin
`ifdef BTN_AUTOREPEAT_EN
                    repeat_nxt = (cnt == CNT_W'(REPEAT_CYC - 1));
                    cnt_nxt    = repeat_nxt ? '0 : cnt + 1'b1;
`else
                    cnt_nxt = '0;
`endif
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end
    always_ff @(posedge clk_slow or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_press   <= 1'b0;
            long_press    <= 1'b0;
            held          <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            press_pulse   <= press_nxt;
            release_pulse <= release_nxt;
            short_press   <= short_nxt;
            long_press    <= long_nxt;
            held          <= (state_nxt != IDLE);
        end
    end
`ifdef BTN_AUTOREPEAT_EN
    always_ff @(posedge clk_slow or negedge rst_n) begin
        if (!rst_n) repeat_pulse <= 1'b0;
        else        repeat_pulse <= repeat_nxt;
    end
`else
    assign repeat_pulse = 1'b0;
    logic unused_repeat;
    assign unused_repeat = repeat_nxt;
`endif
endmodule
